// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute/memory boundary: icodes, register IDs,
// condition selectors and condition-code bit positions.
package y86_pkg;

    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;

    localparam logic [3:0] RNONE = 4'hF;

    // ifun values that select a jXX/cmovXX condition
    localparam logic [3:0] COND_ALWAYS = 4'h0;
    localparam logic [3:0] COND_LE     = 4'h1;
    localparam logic [3:0] COND_L      = 4'h2;
    localparam logic [3:0] COND_E      = 4'h3;
    localparam logic [3:0] COND_NE     = 4'h4;
    localparam logic [3:0] COND_GE     = 4'h5;
    localparam logic [3:0] COND_G      = 4'h6;
    localparam logic [3:0] COND_B      = 4'h7;

    // CC register layout is {CF, OF, SF, ZF}
    localparam int CC_ZF = 0;
    localparam int CC_SF = 1;
    localparam int CC_OF = 2;
    localparam int CC_CF = 3;

    localparam logic [3:0] CC_RESET = 4'b0001;

    function automatic logic [3:0] pack_cc(input logic cf, input logic of,
                                           input logic sf, input logic zf);
        logic [3:0] cc;
        cc        = '0;
        cc[CC_CF] = cf;
        cc[CC_OF] = of;
        cc[CC_SF] = sf;
        cc[CC_ZF] = zf;
        return cc;
    endfunction

endpackage

// File: rtl/cc_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from a stored CC value.
// The borrow condition (ifun 7) exists only when EXEC_CC_CF_EN is defined.
module cc_cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd
);

    logic zf;
    logic sf;
    logic of;
    logic sf_xor_of;

    assign zf        = cc[CC_ZF];
    assign sf        = cc[CC_SF];
    assign of        = cc[CC_OF];
    assign sf_xor_of = sf ^ of;

`ifdef EXEC_CC_CF_EN
    logic cf;
    assign cf = cc[CC_CF];
`else
    logic unused_cf;
    assign unused_cf = cc[CC_CF];
`endif

    always_comb begin
        cnd = 1'b0;
        case (ifun)
            COND_ALWAYS: cnd = 1'b1;
            COND_LE:     cnd = sf_xor_of | zf;
            COND_L:      cnd = sf_xor_of;
            COND_E:      cnd = zf;
            COND_NE:     cnd = ~zf;
            COND_GE:     cnd = ~sf_xor_of;
            COND_G:      cnd = ~sf_xor_of & ~zf;
`ifdef EXEC_CC_CF_EN
            COND_B:      cnd = cf;
`endif
            default:     cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_cc_pipe.sv
// Execute-stage tail: derives Y86 condition codes from the ALU result, holds the
// CC register, evaluates e_cnd and forms the E->M pipeline register. CF tracking
// and the ifun 7 (below) condition are enabled by defining EXEC_CC_CF_EN.
module execute_cc_pipe
    import y86_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e_valid,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [W-1:0] alu_y,
    input  logic         alu_co,
    input  logic         alu_a_msb,
    input  logic         alu_b_msb,
    input  logic         alu_sub,
    input  logic         alu_logic,
    input  logic         set_cc,
    input  logic         cc_inhibit,
    input  logic [W-1:0] e_valA,
    input  logic [3:0]   e_dstE,
    input  logic [3:0]   e_dstM,
    input  logic         m_stall,
    input  logic         m_bubble,
    output logic [3:0]   cc_out,
    output logic         e_cnd,
    output logic         m_valid,
    output logic [3:0]   m_icode,
    output logic         m_cnd,
    output logic [W-1:0] m_valE,
    output logic [W-1:0] m_valA,
    output logic [3:0]   m_dstE,
    output logic [3:0]   m_dstM
);

    // No handshake: pipeline control keeps every E-stage input and the
    // m_stall/m_bubble controls stable ahead of each rising edge, where
    // CC and M are both captured.

    logic [3:0]   cc_q, cc_d;
    logic         m_valid_q, m_valid_d;
    logic [3:0]   m_icode_q, m_icode_d;
    logic         m_cnd_q, m_cnd_d;
    logic [W-1:0] m_valE_q, m_valE_d;
    logic [W-1:0] m_valA_q, m_valA_d;
    logic [3:0]   m_dstE_q, m_dstE_d;
    logic [3:0]   m_dstM_q, m_dstM_d;

    logic flag_zf;
    logic flag_sf;
    logic flag_of;
    logic flag_cf;
    logic y_msb;
    logic cc_en;

    assign y_msb   = alu_y[W-1];
    assign flag_zf = (alu_y == '0);
    assign flag_sf = y_msb;

    always_comb begin
        flag_of = 1'b0;
        if (alu_logic) begin
            flag_of = 1'b0;
        end else if (alu_sub) begin
            // valB - valA overflows when the operands differ in sign and
            // the result's sign no longer matches valB
            flag_of = (alu_a_msb != alu_b_msb) & (y_msb != alu_b_msb);
        end else begin
            flag_of = (alu_a_msb == alu_b_msb) & (y_msb != alu_a_msb);
        end
    end

`ifdef EXEC_CC_CF_EN
    assign flag_cf = alu_co & ~alu_logic;
`else
    logic unused_alu_co;
    assign unused_alu_co = alu_co;
    assign flag_cf       = 1'b0;
`endif

    // A stalled M stage also freezes CC so a replayed OPq cannot update it twice
    assign cc_en = set_cc & e_valid & ~cc_inhibit & ~m_stall;

    always_comb begin
        cc_d = cc_q;
        if (cc_en) begin
            cc_d = pack_cc(flag_cf, flag_of, flag_sf, flag_zf);
        end
    end

    cc_cond_eval u_cond (
        .cc   (cc_q),
        .ifun (e_ifun),
        .cnd  (e_cnd)
    );

    always_comb begin
        m_valid_d = m_valid_q;
        m_icode_d = m_icode_q;
        m_cnd_d   = m_cnd_q;
        m_valE_d  = m_valE_q;
        m_valA_d  = m_valA_q;
        m_dstE_d  = m_dstE_q;
        m_dstM_d  = m_dstM_q;
        if (m_stall) begin
            // hold; stall takes priority over a simultaneous bubble
        end else if (m_bubble) begin
            m_valid_d = 1'b0;
            m_icode_d = ICODE_NOP;
            m_cnd_d   = 1'b0;
            m_valE_d  = '0;
            m_valA_d  = '0;
            m_dstE_d  = RNONE;
            m_dstM_d  = RNONE;
        end else begin
            m_valid_d = e_valid;
            m_icode_d = e_icode;
            m_cnd_d   = e_cnd;
            m_valE_d  = alu_y;
            m_valA_d  = e_valA;
            m_dstM_d  = e_dstM;
            m_dstE_d  = (e_icode == ICODE_CMOVXX && !e_cnd) ? RNONE : e_dstE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q      <= CC_RESET;
            m_valid_q <= 1'b0;
            m_icode_q <= ICODE_NOP;
            m_cnd_q   <= 1'b0;
            m_valE_q  <= '0;
            m_valA_q  <= '0;
            m_dstE_q  <= RNONE;
            m_dstM_q  <= RNONE;
        end else begin
            cc_q      <= cc_d;
            m_valid_q <= m_valid_d;
            m_icode_q <= m_icode_d;
            m_cnd_q   <= m_cnd_d;
            m_valE_q  <= m_valE_d;
            m_valA_q  <= m_valA_d;
            m_dstE_q  <= m_dstE_d;
            m_dstM_q  <= m_dstM_d;
        end
    end

    assign cc_out  = cc_q;
    assign m_valid = m_valid_q;
    assign m_icode = m_icode_q;
    assign m_cnd   = m_cnd_q;
    assign m_valE  = m_valE_q;
    assign m_valA  = m_valA_q;
    assign m_dstE  = m_dstE_q;
    assign m_dstM  = m_dstM_q;

endmodule

// File: tb/tb_execute_cc_pipe.sv
// Bench for execute_cc_pipe: directed cases from the block's behaviour plus
// randomized traffic compared against a flag-level reference model.
module tb_execute_cc_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         e_valid;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] alu_y;
    logic         alu_co;
    logic         alu_a_msb;
    logic         alu_b_msb;
    logic         alu_sub;
    logic         alu_logic;
    logic         set_cc;
    logic         cc_inhibit;
    logic [W-1:0] e_valA;
    logic [3:0]   e_dstE;
    logic [3:0]   e_dstM;
    logic         m_stall;
    logic         m_bubble;
    logic [3:0]   cc_out;
    logic         e_cnd;
    logic         m_valid;
    logic [3:0]   m_icode;
    logic         m_cnd;
    logic [W-1:0] m_valE;
    logic [W-1:0] m_valA;
    logic [3:0]   m_dstE;
    logic [3:0]   m_dstM;

    int n_vec = 0;
    int n_bad = 0;

`ifdef EXEC_CC_CF_EN
    localparam bit CF_EN = 1'b1;
`else
    localparam bit CF_EN = 1'b0;
`endif

    // reference model state: flags as separate booleans, M as plain fields
    bit           x_zf, x_sf, x_of, x_cf;
    bit           x_valid;
    logic [3:0]   x_icode;
    bit           x_cnd;
    logic [W-1:0] x_valE;
    logic [W-1:0] x_valA;
    logic [3:0]   x_dstE;
    logic [3:0]   x_dstM;

    execute_cc_pipe #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .e_valid    (e_valid),
        .e_icode    (e_icode),
        .e_ifun     (e_ifun),
        .alu_y      (alu_y),
        .alu_co     (alu_co),
        .alu_a_msb  (alu_a_msb),
        .alu_b_msb  (alu_b_msb),
        .alu_sub    (alu_sub),
        .alu_logic  (alu_logic),
        .set_cc     (set_cc),
        .cc_inhibit (cc_inhibit),
        .e_valA     (e_valA),
        .e_dstE     (e_dstE),
        .e_dstM     (e_dstM),
        .m_stall    (m_stall),
        .m_bubble   (m_bubble),
        .cc_out     (cc_out),
        .e_cnd      (e_cnd),
        .m_valid    (m_valid),
        .m_icode    (m_icode),
        .m_cnd      (m_cnd),
        .m_valE     (m_valE),
        .m_valA     (m_valA),
        .m_dstE     (m_dstE),
        .m_dstM     (m_dstM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_cnd(input logic [3:0] ifun);
        bit lt;
        lt = (x_sf != x_of);
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return lt || x_zf;
            4'd2:    return lt;
            4'd3:    return x_zf;
            4'd4:    return !x_zf;
            4'd5:    return !lt;
            4'd6:    return !lt && !x_zf;
            4'd7:    return CF_EN ? x_cf : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        {x_cf, x_of, x_sf, x_zf} = 4'b0001;
        x_valid = 1'b0;
        x_icode = 4'h1;
        x_cnd   = 1'b0;
        x_valE  = '0;
        x_valA  = '0;
        x_dstE  = 4'hF;
        x_dstM  = 4'hF;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".cc_out"},  64'(cc_out),  64'({x_cf, x_of, x_sf, x_zf}));
        chk({tag, ".m_valid"}, 64'(m_valid), 64'(x_valid));
        chk({tag, ".m_icode"}, 64'(m_icode), 64'(x_icode));
        chk({tag, ".m_cnd"},   64'(m_cnd),   64'(x_cnd));
        chk({tag, ".m_valE"},  64'(m_valE),  64'(x_valE));
        chk({tag, ".m_valA"},  64'(m_valA),  64'(x_valA));
        chk({tag, ".m_dstE"},  64'(m_dstE),  64'(x_dstE));
        chk({tag, ".m_dstM"},  64'(m_dstM),  64'(x_dstM));
    endtask

    // Inputs are already driven; check e_cnd, advance model and DUT one edge, compare.
    task automatic step(input string tag);
        bit cnd_now, upd, a_neg, b_neg, y_neg, nz, nsg, nov, ncy;
        #1;
        cnd_now = model_cnd(e_ifun);
        chk({tag, ".e_cnd"}, 64'(e_cnd), 64'(cnd_now));
        upd   = set_cc && e_valid && !cc_inhibit && !m_stall;
        a_neg = alu_a_msb;
        b_neg = alu_b_msb;
        y_neg = alu_y[W-1];
        nz    = (alu_y == 0);
        nsg   = y_neg;
        if (alu_logic)    nov = 1'b0;
        else if (alu_sub) nov = (a_neg != b_neg) && (y_neg != b_neg);
        else              nov = (a_neg == b_neg) && (y_neg != a_neg);
        ncy = CF_EN && alu_co && !alu_logic;
        @(posedge clk);
        #1;
        if (upd) {x_cf, x_of, x_sf, x_zf} = {ncy, nov, nsg, nz};
        if (!m_stall) begin
            if (m_bubble) begin
                x_valid = 1'b0; x_icode = 4'h1; x_cnd = 1'b0;
                x_valE = '0; x_valA = '0; x_dstE = 4'hF; x_dstM = 4'hF;
            end else begin
                x_valid = e_valid; x_icode = e_icode; x_cnd = cnd_now;
                x_valE = alu_y; x_valA = e_valA; x_dstM = e_dstM;
                x_dstE = (e_icode == 4'h2 && !cnd_now) ? 4'hF : e_dstE;
            end
        end
        check_state(tag);
    endtask

    task automatic drive_idle();
        e_valid = 1'b1; e_icode = 4'h6; e_ifun = 4'h0;
        alu_y = 32'h0000_0001; alu_co = 1'b0;
        alu_a_msb = 1'b0; alu_b_msb = 1'b0; alu_sub = 1'b0; alu_logic = 1'b0;
        set_cc = 1'b0; cc_inhibit = 1'b0;
        e_valA = 32'h1234_5678; e_dstE = 4'h4; e_dstM = 4'hF;
        m_stall = 1'b0; m_bubble = 1'b0;
    endtask

    task automatic drive_random();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2: e_icode = 4'h6;
            3, 4:    e_icode = 4'h7;
            5, 6:    e_icode = 4'h2;
            7:       e_icode = 4'h1;
            default: e_icode = 4'($urandom_range(0, 15));
        endcase
        e_ifun = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
        r = $urandom_range(0, 5);
        case (r)
            0:       alu_y = '0;
            1:       alu_y = 32'h8000_0000;
            2:       alu_y = 32'h7FFF_FFFF;
            default: alu_y = $urandom;
        endcase
        e_valid    = ($urandom_range(0, 7) != 0);
        alu_co     = 1'($urandom_range(0, 1));
        alu_a_msb  = 1'($urandom_range(0, 1));
        alu_b_msb  = 1'($urandom_range(0, 1));
        alu_sub    = 1'($urandom_range(0, 1));
        alu_logic  = ($urandom_range(0, 3) == 0);
        set_cc     = 1'($urandom_range(0, 1));
        cc_inhibit = ($urandom_range(0, 7) == 0);
        e_valA     = $urandom;
        e_dstE     = 4'($urandom_range(0, 15));
        e_dstM     = 4'($urandom_range(0, 15));
        m_stall    = ($urandom_range(0, 7) == 0);
        m_bubble   = ($urandom_range(0, 7) == 0);
    endtask

    // Reset asserted between clock edges must take effect without an edge.
    task automatic mid_cycle_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".cc_out"}, 64'(cc_out), 64'(4'b0001));
        chk({tag, ".m_icode"}, 64'(m_icode), 64'(4'h1));
        chk({tag, ".m_dstE"}, 64'(m_dstE), 64'(4'hF));
        check_state(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        drive_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b0;

        // load some state, then reset in the middle of a cycle
        drive_idle();
        set_cc = 1'b1; alu_y = 32'h8000_0000;
        step("preload");
        mid_cycle_reset("async_rst");

        // subq giving overflow: 1xxx - 0xxx -> 0x7FFFFFFF
        drive_idle();
        e_ifun = 4'h1; alu_sub = 1'b1; alu_a_msb = 1'b0; alu_b_msb = 1'b1;
        alu_y = 32'h7FFF_FFFF; set_cc = 1'b1;
        step("subq");
        chk("subq.cc_lit", 64'(cc_out), 64'(4'b0100));
        drive_idle();
        e_icode = 4'h7; e_ifun = 4'h2;
        #1;
        chk("jl.e_cnd_lit", 64'(e_cnd), 64'(1));
        step("jl");

        // cmove with ZF clear squashes dstE
        drive_idle();
        e_icode = 4'h2; e_ifun = 4'h3; e_dstE = 4'h3;
        step("cmove_nz");
        chk("cmove_nz.dstE_lit", 64'(m_dstE), 64'(4'hF));

        // inhibited CC update: CC keeps 0100, data still flows
        drive_idle();
        set_cc = 1'b1; cc_inhibit = 1'b1; alu_y = '0;
        step("inhibit");
        chk("inhibit.cc_lit", 64'(cc_out), 64'(4'b0100));
        chk("inhibit.valE_lit", 64'(m_valE), 64'(0));

        // set ZF, then cmove commits
        drive_idle();
        set_cc = 1'b1; alu_y = '0;
        step("zero");
        drive_idle();
        e_icode = 4'h2; e_ifun = 4'h3; e_dstE = 4'h3;
        step("cmove_z");
        chk("cmove_z.dstE_lit", 64'(m_dstE), 64'(4'h3));

        // stall and bubble together: everything holds
        drive_idle();
        m_stall = 1'b1; m_bubble = 1'b1; set_cc = 1'b1; alu_y = 32'hDEAD_BEEF;
        e_icode = 4'h6; e_dstE = 4'h7;
        step("stall_bubble");
        chk("stall_bubble.cc_lit", 64'(cc_out), 64'(4'b0001));
        chk("stall_bubble.dstE_lit", 64'(m_dstE), 64'(4'h3));
        drive_idle();
        m_bubble = 1'b1;
        step("bubble");
        chk("bubble.valid_lit", 64'(m_valid), 64'(0));
        chk("bubble.icode_lit", 64'(m_icode), 64'(4'h1));

        // carry out of an addq, then jb
        drive_idle();
        set_cc = 1'b1; alu_co = 1'b1; alu_y = 32'h0000_0005;
        step("addq_co");
        chk("addq_co.cf_lit", 64'(cc_out[3]), 64'(CF_EN));
        drive_idle();
        e_icode = 4'h7; e_ifun = 4'h7;
        #1;
        chk("jb.e_cnd_lit", 64'(e_cnd), 64'(CF_EN));
        step("jb");

        // randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step("rand");
            if ($urandom_range(0, 299) == 0) mid_cycle_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
